// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl
// Hazard controller for the execute stage of the 5-stage core. It keeps a
// shadow copy of the EX, MEM and WB stage bookkeeping. From that copy it
// drives the ALU operand forwarding selects, detects load-use hazards and
// inserts one bubble for each, turns a taken branch or jump in EX into a PC
// redirect plus flush, freezes the pipe while data memory is busy, and counts
// stall and flush cycles.
//
// Handshake: the pipeline advances on every rising clk edge unless
// mem_busy_i is high. No other valid/ready pairing exists here. id_valid_i
// marks the ID instruction as live, and the *_valid_o outputs mark the
// shadow stages as live.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   id_*_i                   decoded fields of the instruction in ID
//   ex_branch_jump_i         ALU says the EX instruction changes flow
//   ex_pc_next_i             ALU computed next PC for the EX instruction
//   mem_busy_i               data memory not ready, freeze everything
//   if_stall_o, id_stall_o   hold PC and IF/ID
//   id_flush_o, ex_flush_o   bubble into IF/ID, ID/EX
//   redirect_valid_o/pc_o    PC load request and target
//   fwd_rs1/rs2_sel_o        00 regfile, 01 EX/MEM, 10 MEM/WB
//   ex/mem/wb_valid_o        shadow stage valid bits
//   stall_cnt_o, flush_cnt_o performance counters, wrap silently
module ex_hazard_ctrl #(
  parameter int REG_WIDTH = 5,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid_i,
  input  logic [REG_WIDTH-1:0] id_rs1_i,
  input  logic [REG_WIDTH-1:0] id_rs2_i,
  input  logic                 id_rs1_used_i,
  input  logic                 id_rs2_used_i,
  input  logic [REG_WIDTH-1:0] id_rd_i,
  input  logic                 id_rd_we_i,
  input  logic                 id_is_load_i,
  input  logic                 ex_branch_jump_i,
  input  logic [31:0]          ex_pc_next_i,
  input  logic                 mem_busy_i,
  output logic                 if_stall_o,
  output logic                 id_stall_o,
  output logic                 id_flush_o,
  output logic                 ex_flush_o,
  output logic                 redirect_valid_o,
  output logic [31:0]          redirect_pc_o,
  output logic [1:0]           fwd_rs1_sel_o,
  output logic [1:0]           fwd_rs2_sel_o,
  output logic                 ex_valid_o,
  output logic                 mem_valid_o,
  output logic                 wb_valid_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  // EX entry
  logic                 ex_valid;
  logic [REG_WIDTH-1:0] ex_rd;
  logic                 ex_we;
  logic                 ex_load;
  logic [REG_WIDTH-1:0] ex_rs1;
  logic [REG_WIDTH-1:0] ex_rs2;
  logic                 ex_rs1_used;
  logic                 ex_rs2_used;
  // MEM entry
  logic                 mem_valid;
  logic [REG_WIDTH-1:0] mem_rd;
  logic                 mem_we;
  logic                 mem_load;
  // WB entry
  logic                 wb_valid;
  logic [REG_WIDTH-1:0] wb_rd;
  logic                 wb_we;

  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  logic adv;
  logic lu;
  logic redirect;
  logic ex_load_live;
  logic rs1_dep;
  logic rs2_dep;
  logic load_bubble;

  assign adv = ~mem_busy_i;

  // A load in EX cannot be forwarded to the ID instruction in time; x0 and
  // non-writing loads never create a dependency.
  assign ex_load_live = ex_valid & ex_load & ex_we & (ex_rd != '0);
  assign rs1_dep      = id_rs1_used_i & (id_rs1_i == ex_rd);
  assign rs2_dep      = id_rs2_used_i & (id_rs2_i == ex_rd);
  assign lu           = id_valid_i & ex_load_live & (rs1_dep | rs2_dep);

  // Redirect only fires when the pipe actually advances. A branch held
  // during a freeze therefore redirects exactly once, on the first free cycle.
  assign redirect = ex_valid & ex_branch_jump_i & adv;

  assign redirect_valid_o = redirect;
  assign redirect_pc_o    = redirect ? ex_pc_next_i : 32'h0;

  // The redirect kills the ID instruction, so a coincident load-use needs no stall.
  assign if_stall_o = ~adv | (lu & ~redirect);
  assign id_stall_o = if_stall_o;
  assign id_flush_o = redirect;
  assign ex_flush_o = adv & (redirect | lu);

  assign load_bubble = ex_flush_o | ~id_valid_i;

  // Forward select for one operand. MEM is checked first, so the youngest
  // producer wins. A load in MEM has no result yet and is not a source.
  function automatic logic [1:0] fwd_sel(
    input logic                 used,
    input logic [REG_WIDTH-1:0] rs,
    input logic                 m_valid,
    input logic                 m_we,
    input logic                 m_load,
    input logic [REG_WIDTH-1:0] m_rd,
    input logic                 w_valid,
    input logic                 w_we,
    input logic [REG_WIDTH-1:0] w_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (used && m_valid && m_we && !m_load && (m_rd != '0) && (m_rd == rs)) begin
      sel = 2'b01;
    end else if (used && w_valid && w_we && (w_rd != '0) && (w_rd == rs)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_rs1_sel_o = fwd_sel(ex_rs1_used, ex_rs1, mem_valid, mem_we, mem_load,
                            mem_rd, wb_valid, wb_we, wb_rd);
    fwd_rs2_sel_o = fwd_sel(ex_rs2_used, ex_rs2, mem_valid, mem_we, mem_load,
                            mem_rd, wb_valid, wb_we, wb_rd);
  end

  // Shadow scoreboard. Reset clears every field immediately, so the forwarding
  // selects drop to 00 without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_rd       <= '0;
      ex_we       <= 1'b0;
      ex_load     <= 1'b0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rs1_used <= 1'b0;
      ex_rs2_used <= 1'b0;
      mem_valid   <= 1'b0;
      mem_rd      <= '0;
      mem_we      <= 1'b0;
      mem_load    <= 1'b0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_we       <= 1'b0;
    end else if (adv) begin
      wb_valid    <= mem_valid;
      wb_rd       <= mem_rd;
      wb_we       <= mem_we;
      mem_valid   <= ex_valid;
      mem_rd      <= ex_rd;
      mem_we      <= ex_we;
      mem_load    <= ex_load;
      ex_valid    <= ~load_bubble;
      ex_rd       <= id_rd_i;
      ex_we       <= id_rd_we_i;
      ex_load     <= id_is_load_i;
      ex_rs1      <= id_rs1_i;
      ex_rs2      <= id_rs2_i;
      // A bubble reads nothing, so its selects stay at 00.
      ex_rs1_used <= id_rs1_used_i & ~load_bubble;
      ex_rs2_used <= id_rs2_used_i & ~load_bubble;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (if_stall_o) begin
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
      if (redirect) begin
        flush_cnt <= flush_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign ex_valid_o  = ex_valid;
  assign mem_valid_o = mem_valid;
  assign wb_valid_o  = wb_valid;
  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;

endmodule
